// File: rtl/demo_arb_pkg.sv
// Shared types and the round-robin pick function for the demo request arbiter.
// ID fields are sized for the largest supported requester count (8).
package demo_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } pipe_ent_t;

  // Returns {found, index}: first set bit of eligible at or after ptr, wrapping at n.
  function automatic logic [ID_W:0] rr_pick(input logic [MAX_REQ-1:0] eligible,
                                            input logic [ID_W-1:0]    ptr,
                                            input int                 n);
    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W+1:0] idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {2'b00, ptr} + (ID_W+2)'(k);
      if (idx >= (ID_W+2)'(n)) idx = idx - (ID_W+2)'(n);
      if ((k < n) && !found && eligible[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
    return {found, win};
  endfunction

endpackage

// File: rtl/demo_rr_grant.sv
// Round-robin grant: combinational one-hot pick from the pointer, zero latency.
// No backpressure of its own; the pointer only advances past a granted index.
module demo_rr_grant
  import demo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] eligible,
  input  logic               gnt_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_vld,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W:0]   pick;

  always_comb begin
    pick    = rr_pick(MAX_REQ'(eligible), rr_ptr, NUM_REQ);
    gnt_vld = gnt_en & pick[ID_W];
    gnt_id  = pick[ID_W-1:0];
    gnt     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = gnt_vld && (gnt_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/demo_req_arb.sv
// Shares one fixed-latency datapath among NUM_REQ requesters; issue T -> response T+DUT_LAT+2.
// One grant per cycle with no stall on response retire; grants stop outside RUN.
module demo_req_arb
  import demo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DUT_LAT    = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_en,
  input  logic [NUM_REQ-1:0]            cfg_mask,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          dut_vld_i,
  output logic [ADDR_WIDTH-1:0]         dut_addr_i,
  output logic [DATA_WIDTH-1:0]         dut_data_i,
  input  logic                          dut_vld_o,
  input  logic [3:0]                    dut_result,
  input  logic [ADDR_WIDTH-1:0]         dut_addr_o,
  input  logic [DATA_WIDTH-1:0]         dut_data_o,
  output logic [NUM_REQ-1:0]            rsp_vld,
  output logic [NUM_REQ-1:0]            rsp_err,
  output logic [3:0]                    rsp_result,
  output logic [ADDR_WIDTH-1:0]         rsp_addr,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy,
  output logic                          drain_done,
  output logic [CNT_WIDTH-1:0]          issue_cnt,
  output logic [CNT_WIDTH-1:0]          drop_cnt,
  output logic                          spurious_err
);

  localparam int PIPE_D = DUT_LAT + 1;

  state_t                state;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    gnt;
  logic                  gnt_vld;
  logic [ID_W-1:0]       gnt_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  pipe_ent_t             pipe [PIPE_D];
  pipe_ent_t             head;

  assign eligible = req_vld & cfg_mask;
  assign req_rdy  = gnt;
  assign head     = pipe[PIPE_D-1];

  demo_rr_grant #(
    .NUM_REQ (NUM_REQ)
  ) u_grant (
    .clk      (clk),
    .rst      (rst),
    .eligible (eligible),
    .gnt_en   (state == RUN),
    .gnt      (gnt),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  // Grant is one-hot, so an OR-mux selects the winner's payload.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = sel_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < PIPE_D; i++) begin
      busy = busy | pipe[i].vld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        IDLE:    if (cfg_en) state <= RUN;
        RUN:     if (!cfg_en) state <= DRAIN;
        DRAIN: begin
          if (cfg_en) begin
            state <= RUN;
          end else if (!busy) begin
            state      <= IDLE;
            drain_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dut_vld_i  <= 1'b0;
      dut_addr_i <= '0;
      dut_data_i <= '0;
      issue_cnt  <= '0;
    end else begin
      dut_vld_i  <= gnt_vld;
      dut_addr_i <= sel_addr;
      dut_data_i <= sel_data;
      if (gnt_vld && (issue_cnt != '1)) issue_cnt <= issue_cnt + 1'b1;
    end
  end

  // Tracking pipe mirrors the datapath latency so the head lines up with dut_vld_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_D; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{vld: gnt_vld, id: gnt_id};
      for (int i = 1; i < PIPE_D; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld      <= '0;
      rsp_err      <= '0;
      rsp_result   <= '0;
      rsp_addr     <= '0;
      rsp_data     <= '0;
      drop_cnt     <= '0;
      spurious_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_vld[i] <= head.vld &&  dut_vld_o && (head.id == ID_W'(i));
        rsp_err[i] <= head.vld && !dut_vld_o && (head.id == ID_W'(i));
      end
      if (head.vld && dut_vld_o) begin
        rsp_result <= dut_result;
        rsp_addr   <= dut_addr_o;
        rsp_data   <= dut_data_o;
      end else begin
        rsp_result <= '0;
        rsp_addr   <= '0;
        rsp_data   <= '0;
      end
      if (head.vld && !dut_vld_o && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      if (!head.vld && dut_vld_o) spurious_err <= 1'b1;
    end
  end

endmodule
